// File: rtl/detector_share_arbiter.sv
// Time-shares one serial pattern detector among NREQ requesters; returns its hit count.
// DETECTOR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round robin.
module detector_share_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int CW   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [CW-1:0]        hit_count,
    output logic                 busy,
    output logic                 fsm_reset,
    output logic                 fsm_in,
    output logic                 fsm_flux,
    input  logic                 fsm_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (DW > 1) ? $clog2(DW) : 1;
    localparam int SW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [CW-1:0]     hit_q, hit_d;
    logic              busy_q, busy_d;
    logic              frst_q, frst_d;
    logic              fin_q, fin_d;
    logic              flux_q, flux_d;
    logic [DW-1:0]     word_q, word_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [PW-1:0]     win_q, win_d;
    logic [PW-1:0]     pick;
    logic              found;

`ifdef DETECTOR_ARB_FIXED_PRIO_EN
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                pick  = PW'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic [PW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] cand;

    // Search starts at the pointer and wraps modulo NREQ.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + SW'(i);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                pick  = cand[PW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        hit_d   = hit_q;
        busy_d  = busy_q;
        frst_d  = frst_q;
        fin_d   = fin_q;
        flux_d  = flux_q;
        word_d  = word_q;
        bit_d   = bit_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                frst_d = 1'b1;
                if (found) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick;
                    win_d   = pick;
                    word_d  = req_data[int'(pick)*DW +: DW];
                    bit_d   = '0;
                    hit_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                state_d = SHIFT;
                frst_d  = 1'b0;
                fin_d   = word_q[DW-1];
                word_d  = word_q << 1;
                flux_d  = ~flux_q;
                bit_d   = '0;
            end
            SHIFT: begin
                if (fsm_out) begin
                    hit_d = hit_q + CW'(1);
                end
                if (bit_q == BW'(DW - 1)) begin
                    state_d = DONE;
                    frst_d  = 1'b1;
                    fin_d   = 1'b0;
                    done_d  = NREQ'(1) << win_q;
                end else begin
                    bit_d  = bit_q + BW'(1);
                    fin_d  = word_q[DW-1];
                    word_d = word_q << 1;
                    flux_d = ~flux_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            hit_q   <= '0;
            busy_q  <= 1'b0;
            frst_q  <= 1'b1;
            fin_q   <= 1'b0;
            flux_q  <= 1'b0;
            word_q  <= '0;
            bit_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
            frst_q  <= frst_d;
            fin_q   <= fin_d;
            flux_q  <= flux_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            win_q   <= win_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign hit_count = hit_q;
    assign busy      = busy_q;
    assign fsm_reset = frst_q;
    assign fsm_in    = fin_q;
    assign fsm_flux  = flux_q;

endmodule
